// File: rtl/mem_bus_target.sv
// Word-addressed RAM responder behind a 4-phase req/ack handshake with programmable wait states.
// Optional macro MEM_BUS_TARGET_ROM_PROTECT_EN makes addresses 0..ROM_WORDS-1 write-protected.
module mem_bus_target #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 2,
    parameter int ROM_WORDS   = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              err
);
    // Handshake: req rises with we/addr/wdata stable and stays high until ack is seen;
    // ack stays high while req is high and drops on the edge after req is sampled low.

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_rd;
    logic              in_range;
    logic              wr_allowed;
    logic              commit;
    logic              mem_we;

    assign in_range = ({1'b0, addr_q} < DEPTH_X);
    assign mem_idx  = addr_q[IDX_W-1:0];
    assign mem_rd   = mem[mem_idx];

`ifdef MEM_BUS_TARGET_ROM_PROTECT_EN
    localparam logic [ADDR_W:0] ROM_X = (ADDR_W + 1)'(ROM_WORDS);
    assign wr_allowed = in_range && ({1'b0, addr_q} >= ROM_X);
`else
    assign wr_allowed = in_range;
`endif

    // WAIT spans the capture cycle plus WAIT_CYCLES wait states, so the access
    // commits (and ack rises) WAIT_CYCLES+1 edges after the capture edge.
    assign commit = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign mem_we = commit && we_q && wr_allowed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // Storage is not reset; a write is only ever issued on the commit edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= wdata_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    we_d    = we;
                    wdata_d = wdata;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (!req) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        ack_d   = ack_q;
        err_d   = err_q;
        if (commit) begin
            ack_d = 1'b1;
            if (we_q) begin
                err_d = !wr_allowed;
            end else begin
                err_d   = !in_range;
                rdata_d = in_range ? mem_rd : '1;
            end
        end else if ((state_q == ST_RESP) && !req) begin
            ack_d = 1'b0;
            err_d = 1'b0;
        end
    end

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign err   = err_q;

endmodule
